// File: rtl/aircon_mode_controller_if.sv
`default_nettype none
// ============================================================================
//  Module  : aircon_mode_controller_if
//  Brief   : Panel-side bundle: power button, valid/ready command port and
//            live setting outputs of the air-conditioner mode controller.
//  Revision: 1.0 - initial release
// ============================================================================
interface aircon_mode_controller_if;
    logic       pwr_btn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [4:0] cmd_data;
    logic       power;
    logic [4:0] temp;
    logic [4:0] cap;
    logic [4:0] fan;
    logic [4:0] timer;
    logic       expired;

    modport master (
        output pwr_btn, cmd_valid, cmd_sel, cmd_data,
        input  cmd_ready, power, temp, cap, fan, timer, expired
    );

    modport slave (
        input  pwr_btn, cmd_valid, cmd_sel, cmd_data,
        output cmd_ready, power, temp, cap, fan, timer, expired
    );
endinterface
`default_nettype wire

// File: rtl/aircon_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module  : aircon_mode_controller
//  Brief   : Power FSM, clamped settings write port and sleep-timer countdown
//            with automatic power-off for the air-conditioner datapath.
//  Revision: 1.0 - initial release
// ============================================================================
module aircon_mode_controller #(
    parameter int TICKS_PER_MIN = 60,
    parameter int TEMP_MIN      = 17,
    parameter int TEMP_MAX      = 30,
    parameter int TEMP_DEFAULT  = 24,
    parameter int FAN_DEFAULT   = 1,
    parameter int CAP_DEFAULT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    aircon_mode_controller_if.slave bus
);

    localparam int                  c_PRESC_W    = $clog2(TICKS_PER_MIN);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICKS_PER_MIN - 1);
    localparam logic [4:0]          c_TEMP_MIN   = 5'(TEMP_MIN);
    localparam logic [4:0]          c_TEMP_MAX   = 5'(TEMP_MAX);
    localparam logic [4:0]          c_TEMP_DEF   = 5'(TEMP_DEFAULT);
    localparam logic [2:0]          c_FAN_DEF    = 3'(FAN_DEFAULT);
    localparam logic [1:0]          c_CAP_DEF    = 2'(CAP_DEFAULT);

    localparam logic [1:0] c_SEL_TEMP  = 2'b00;
    localparam logic [1:0] c_SEL_CAP   = 2'b01;
    localparam logic [1:0] c_SEL_FAN   = 2'b10;
    localparam logic [1:0] c_SEL_TIMER = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_TIMED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_temp;
    logic [1:0]             r_cap;
    logic [2:0]             r_fan;
    logic [4:0]             r_timer;
    logic [c_PRESC_W-1:0]   r_presc;
    logic                   r_expired;

    logic                   w_power;
    logic                   w_expire_now;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_timer_wr;
    logic [4:0]             w_temp_clamped;

    assign w_power      = (r_state != ST_OFF);
    assign w_expire_now = (r_state == ST_TIMED) && (r_presc == c_PRESC_LAST)
                          && (r_timer == 5'd1);
    // Button and expiry both win over a same-cycle command; the master must hold it.
    assign w_ready      = w_power && !bus.pwr_btn && !w_expire_now;
    assign w_accept     = bus.cmd_valid && w_ready;
    assign w_timer_wr   = w_accept && (bus.cmd_sel == c_SEL_TIMER);

    always_comb begin
        w_temp_clamped = bus.cmd_data;
        if (bus.cmd_data < c_TEMP_MIN) begin
            w_temp_clamped = c_TEMP_MIN;
        end else if (bus.cmd_data > c_TEMP_MAX) begin
            w_temp_clamped = c_TEMP_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF: begin
                if (bus.pwr_btn) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (bus.pwr_btn) begin
                    w_state_nxt = ST_OFF;
                end else if (w_timer_wr && (bus.cmd_data != 5'd0)) begin
                    w_state_nxt = ST_TIMED;
                end
            end
            ST_TIMED: begin
                if (bus.pwr_btn || w_expire_now) begin
                    w_state_nxt = ST_OFF;
                end else if (w_timer_wr && (bus.cmd_data == 5'd0)) begin
                    w_state_nxt = ST_ON;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // Timer and prescaler: cleared on entry to OFF, reloaded on a timer write,
    // otherwise counting only while TIMED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= 5'd0;
            r_presc   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= w_expire_now;
            if (w_state_nxt == ST_OFF) begin
                r_timer <= 5'd0;
                r_presc <= '0;
            end else if (w_timer_wr) begin
                r_timer <= bus.cmd_data;
                r_presc <= '0;
            end else if (r_state == ST_TIMED) begin
                if (r_presc == c_PRESC_LAST) begin
                    r_presc <= '0;
                    if (r_timer != 5'd0) begin
                        r_timer <= r_timer - 5'd1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end else begin
                r_presc <= '0;
            end
        end
    end

    // Settings survive power-off; only reset restores the defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_temp <= c_TEMP_DEF;
            r_cap  <= c_CAP_DEF;
            r_fan  <= c_FAN_DEF;
        end else if (w_accept) begin
            case (bus.cmd_sel)
                c_SEL_TEMP: r_temp <= w_temp_clamped;
                c_SEL_CAP:  r_cap  <= bus.cmd_data[1:0];
                c_SEL_FAN:  r_fan  <= bus.cmd_data[2:0];
                default:    ;
            endcase
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.power     = w_power;
    assign bus.temp      = w_power ? r_temp : 5'd0;
    assign bus.cap       = w_power ? {3'b000, r_cap} : 5'd0;
    assign bus.fan       = w_power ? {2'b00, r_fan} : 5'd0;
    assign bus.timer     = r_timer;
    assign bus.expired   = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_aircon_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module  : tb_aircon_mode_controller
//  Brief   : Table vectors, directed corner sequences and random traffic
//            checked against a cycle-count reference model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_aircon_mode_controller;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aircon_mode_controller_if bus ();

    aircon_mode_controller #(
        .TICKS_PER_MIN(T), .TEMP_MIN(17), .TEMP_MAX(30),
        .TEMP_DEFAULT(24), .FAN_DEFAULT(1), .CAP_DEFAULT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the countdown is "cycles elapsed since load" against N*T.
    bit m_on, m_timed, m_expired;
    int m_temp, m_cap, m_fan, m_n, m_cnt;
    logic last_ready;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_exp_now();
        return m_timed && (m_cnt == m_n * T - 1);
    endfunction

    function automatic int m_timer();
        return m_timed ? (m_n - m_cnt / T) : 0;
    endfunction

    task automatic m_reset();
        m_on = 0; m_timed = 0; m_expired = 0;
        m_temp = 24; m_cap = 1; m_fan = 1; m_n = 0; m_cnt = 0;
    endtask

    task automatic m_update(input bit r, input bit pb, input bit v, input int sel, input int d);
        bit ex;
        ex = m_exp_now();
        if (r) begin
            m_reset();
        end else if (!m_on) begin
            m_expired = 0;
            if (pb) m_on = 1;
        end else begin
            m_expired = ex;
            if (pb || ex) begin
                m_on = 0; m_timed = 0; m_cnt = 0;
            end else if (v && sel == 3) begin
                if (d == 0) m_timed = 0;
                else begin m_timed = 1; m_n = d; m_cnt = 0; end
            end else begin
                if (v && sel == 0) m_temp = (d < 17) ? 17 : (d > 30) ? 30 : d;
                if (v && sel == 1) m_cap = d % 4;
                if (v && sel == 2) m_fan = d % 8;
                if (m_timed) m_cnt++;
            end
        end
    endtask

    task automatic step(input bit r, input bit pb, input bit v, input int sel, input int d);
        rst = r;
        bus.pwr_btn = pb;
        bus.cmd_valid = v;
        bus.cmd_sel = 2'(sel);
        bus.cmd_data = 5'(d);
        #1;
        last_ready = bus.cmd_ready;
        chk("cmd_ready", int'(bus.cmd_ready), int'(m_on && !pb && !m_exp_now()));
        @(posedge clk);
        m_update(r, pb, v, sel, d);
        #1;
        chk("power", int'(bus.power), int'(m_on));
        chk("temp", int'(bus.temp), m_on ? m_temp : 0);
        chk("cap", int'(bus.cap), m_on ? m_cap : 0);
        chk("fan", int'(bus.fan), m_on ? m_fan : 0);
        chk("timer", int'(bus.timer), m_timer());
        chk("expired", int'(bus.expired), int'(m_expired));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit r, pb, v;
        int sel, d;
        int power, temp, cap, fan, timer;
    } vec_t;

    vec_t tbl[10];
    bit   saw_exp;

    initial begin
        bus.pwr_btn = 0; bus.cmd_valid = 0; bus.cmd_sel = 0; bus.cmd_data = 0;
        m_reset();
        last_ready = 0;

        tbl[0] = '{1, 0, 0, 0, 0,  0,  0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0,  0,  0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0,  1, 24, 1, 1, 0};
        tbl[3] = '{0, 0, 1, 0, 5,  1, 17, 1, 1, 0};
        tbl[4] = '{0, 0, 1, 0, 31, 1, 30, 1, 1, 0};
        tbl[5] = '{0, 0, 1, 0, 22, 1, 22, 1, 1, 0};
        tbl[6] = '{0, 0, 1, 1, 7,  1, 22, 3, 1, 0};
        tbl[7] = '{0, 0, 1, 2, 5,  1, 22, 3, 5, 0};
        tbl[8] = '{0, 0, 1, 2, 0,  1, 22, 3, 0, 0};
        tbl[9] = '{0, 0, 1, 2, 3,  1, 22, 3, 3, 0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].pb, tbl[i].v, tbl[i].sel, tbl[i].d);
            chk("tbl_power", int'(bus.power), tbl[i].power);
            chk("tbl_temp",  int'(bus.temp),  tbl[i].temp);
            chk("tbl_cap",   int'(bus.cap),   tbl[i].cap);
            chk("tbl_fan",   int'(bus.fan),   tbl[i].fan);
            chk("tbl_timer", int'(bus.timer), tbl[i].timer);
        end

        // Timer of 2 minutes: drops to 1 after T cycles, expires at 2*T.
        step(0, 0, 1, 3, 2);
        chk("a_timer_load", int'(bus.timer), 2);
        idle(3);
        chk("a_timer_hold", int'(bus.timer), 2);
        idle(1);
        chk("a_timer_dec", int'(bus.timer), 1);
        idle(3);
        chk("a_pre_expire", int'(bus.expired), 0);
        chk("a_pre_power", int'(bus.power), 1);
        idle(1);
        chk("a_expired", int'(bus.expired), 1);
        chk("a_power_off", int'(bus.power), 0);
        chk("a_timer_zero", int'(bus.timer), 0);
        idle(1);
        chk("a_pulse_len", int'(bus.expired), 0);
        step(0, 1, 0, 0, 0);
        chk("a_restore_temp", int'(bus.temp), 22);
        chk("a_restore_cap", int'(bus.cap), 3);
        chk("a_restore_fan", int'(bus.fan), 3);
        chk("a_restore_timer", int'(bus.timer), 0);

        // Cancel a running timer with a zero write.
        step(0, 0, 1, 3, 3);
        idle(5);
        step(0, 0, 1, 3, 0);
        chk("b_power", int'(bus.power), 1);
        chk("b_timer", int'(bus.timer), 0);
        saw_exp = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            if (bus.expired) saw_exp = 1;
        end
        chk("b_no_expire", int'(saw_exp), 0);

        // Button beats a same-cycle command.
        step(0, 1, 1, 0, 20);
        chk("c_ready_blocked", int'(last_ready), 0);
        chk("c_power_off", int'(bus.power), 0);
        step(0, 1, 0, 0, 0);
        chk("c_temp_kept", int'(bus.temp), 22);

        // Reset mid-countdown.
        step(0, 0, 1, 3, 5);
        idle(7);
        step(1, 0, 0, 0, 0);
        chk("d_power", int'(bus.power), 0);
        chk("d_timer", int'(bus.timer), 0);
        chk("d_temp", int'(bus.temp), 0);
        saw_exp = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 0);
            if (bus.expired) saw_exp = 1;
        end
        chk("d_no_expire", int'(saw_exp), 0);
        step(0, 1, 0, 0, 0);
        chk("d_def_temp", int'(bus.temp), 24);
        chk("d_def_fan", int'(bus.fan), 1);
        chk("d_def_cap", int'(bus.cap), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int sel, d;
            sel = int'($urandom_range(0, 3));
            d = (sel == 3) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 31));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0),
                 sel, d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
